// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of predicted branches between fetch and
// execute. The oldest entry is resolved against the actual outcome. The block
// produces a training strobe for every resolve, and a redirect plus full flush
// on a mispredict. It also counts resolved and mispredicted branches.
module branch_resolve_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 64,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [ADDR_W-1:0] alloc_pc,
    input  logic              alloc_pred_taken,
    input  logic [ADDR_W-1:0] alloc_pred_tgt,
    input  logic              res_valid,
    input  logic              res_taken,
    input  logic [ADDR_W-1:0] res_target,
    output logic              fb_valid,
    output logic [ADDR_W-1:0] fb_pc,
    output logic              fb_taken,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              res_err,
    output logic [CW-1:0]     count,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              pred_taken;
        logic [ADDR_W-1:0] pred_tgt;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head, tail;
    entry_t        hd;
    logic          push, resolve, mispredict;

    // Ready depends only on registered occupancy, so a pop in the same cycle
    // cannot make room for a push.
    assign alloc_ready = (count != CW'(DEPTH));
    assign push        = alloc_valid && alloc_ready;
    assign resolve     = res_valid && (count != '0);
    assign hd          = mem[head];

    // A mispredict is a wrong direction, or a taken branch with a wrong target.
    always_comb begin
        mispredict = (res_taken != hd.pred_taken) ||
                     (res_taken && hd.pred_taken && (res_target != hd.pred_tgt));
    end

    // Entry storage is never cleared. Stale slots are unreachable through the pointers.
    always_ff @(posedge clk) begin
        if (push)
            mem[tail] <= '{pc: alloc_pc, pred_taken: alloc_pred_taken, pred_tgt: alloc_pred_tgt};
    end

    // Pointers and occupancy. A mispredict flushes everything, including a
    // push accepted in the same cycle, because that push is on the wrong path.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (resolve && mispredict) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + 1'b1;
            if (resolve)
                head <= head + 1'b1;
            count <= count + CW'(push) - CW'(resolve);
        end
    end

    // One-cycle strobes and held payloads for training, redirect and error.
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_valid       <= 1'b0;
            fb_pc          <= '0;
            fb_taken       <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            res_err        <= 1'b0;
        end else begin
            fb_valid       <= resolve;
            redirect_valid <= resolve && mispredict;
            res_err        <= res_valid && (count == '0);
            if (resolve) begin
                fb_pc    <= hd.pc;
                fb_taken <= res_taken;
            end
            if (resolve && mispredict)
                redirect_pc <= res_taken ? res_target : hd.pc + ADDR_W'(4);
        end
    end

    // Statistics counters. They wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (resolve) begin
            stat_branches <= stat_branches + 32'd1;
            if (mispredict)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed stimulus. A queue-based reference model
// is checked on every negedge, and literal expectations pin key results.
module tb_branch_resolve_queue;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 64;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              alloc_valid, alloc_ready, alloc_pred_taken;
    logic [ADDR_W-1:0] alloc_pc, alloc_pred_tgt;
    logic              res_valid, res_taken;
    logic [ADDR_W-1:0] res_target;
    logic              fb_valid, fb_taken, redirect_valid, res_err;
    logic [ADDR_W-1:0] fb_pc, redirect_pc;
    logic [CW-1:0]     count;
    logic [31:0]       stat_branches, stat_mispredicts;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    branch_resolve_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_pc(alloc_pc),
        .alloc_pred_taken(alloc_pred_taken), .alloc_pred_tgt(alloc_pred_tgt),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .fb_valid(fb_valid), .fb_pc(fb_pc), .fb_taken(fb_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .res_err(res_err),
        .count(count), .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] pc;
        logic        pt;
        logic [63:0] tgt;
    } ent_t;

    ent_t        q[$];
    bit          m_on = 0;
    bit          m_fbv, m_fbt, m_rv, m_err;
    logic [63:0] m_fbpc, m_rpc;
    int unsigned m_br, m_mis;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_on = 1; m_fbv = 0; m_fbt = 0; m_rv = 0; m_err = 0;
            m_fbpc = 0; m_rpc = 0; m_br = 0; m_mis = 0;
        end else if (m_on) begin
            bit   acc, flush;
            ent_t e;
            acc   = alloc_valid && (q.size() != DEPTH);
            flush = 0;
            m_fbv = 0; m_rv = 0; m_err = 0;
            if (res_valid && q.size() != 0) begin
                e = q.pop_front();
                m_fbv = 1; m_fbpc = e.pc; m_fbt = res_taken;
                m_br++;
                if (res_taken != e.pt || (res_taken && res_target != e.tgt)) begin
                    m_mis++;
                    m_rv  = 1;
                    m_rpc = res_taken ? res_target : e.pc + 64'd4;
                    q.delete();
                    flush = 1;
                end
            end else if (res_valid) begin
                m_err = 1;
            end
            if (acc && !flush)
                q.push_back('{pc: alloc_pc, pt: alloc_pred_taken, tgt: alloc_pred_tgt});
        end
    end

    // Compare every output against the model on every cycle after the first reset.
    always @(negedge clk) begin
        if (m_on) begin
            chk("count",            64'(count),            64'(q.size()));
            chk("alloc_ready",      64'(alloc_ready),      64'(q.size() != DEPTH));
            chk("fb_valid",         64'(fb_valid),         64'(m_fbv));
            chk("fb_pc",            fb_pc,                 m_fbpc);
            chk("fb_taken",         64'(fb_taken),         64'(m_fbt));
            chk("redirect_valid",   64'(redirect_valid),   64'(m_rv));
            chk("redirect_pc",      redirect_pc,           m_rpc);
            chk("res_err",          64'(res_err),          64'(m_err));
            chk("stat_branches",    64'(stat_branches),    64'(m_br));
            chk("stat_mispredicts", 64'(stat_mispredicts), 64'(m_mis));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit av, input logic [63:0] pc, input bit pt, input logic [63:0] tgt,
                        input bit rv, input bit rt, input logic [63:0] rtgt);
        alloc_valid = av; alloc_pc = pc; alloc_pred_taken = pt; alloc_pred_tgt = tgt;
        res_valid = rv; res_taken = rt; res_target = rtgt;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1; idle(); rst = 0;
    endtask

    initial begin
        rst = 1;
        alloc_valid = 0; alloc_pc = 0; alloc_pred_taken = 0; alloc_pred_tgt = 0;
        res_valid = 0; res_taken = 0; res_target = 0;
        @(posedge clk); #1;
        do_reset();
        chk("rst_count",    64'(count),          64'd0);
        chk("rst_ready",    64'(alloc_ready),    64'd1);
        chk("rst_fb_valid", 64'(fb_valid),       64'd0);
        chk("rst_stats",    64'(stat_branches),  64'd0);

        // 1: fill to DEPTH, ninth alloc refused
        for (int i = 0; i < 8; i++) step(1, 64'h100 + 4*i, 0, 0, 0, 0, 0);
        chk("t1_count", 64'(count),       64'd8);
        chk("t1_ready", 64'(alloc_ready), 64'd0);
        step(1, 64'h120, 0, 0, 0, 0, 0);
        chk("t1_count9", 64'(count), 64'd8);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, 0, 0);
        chk("t1_drain_fbpc", fb_pc,              64'h11C);
        chk("t1_drain_br",   64'(stat_branches), 64'd8);

        // 2: correct not-taken prediction
        do_reset();
        step(1, 64'h200, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("t2_fb_valid", 64'(fb_valid),         64'd1);
        chk("t2_fb_pc",    fb_pc,                 64'h200);
        chk("t2_fb_taken", 64'(fb_taken),         64'd0);
        chk("t2_redirect", 64'(redirect_valid),   64'd0);
        chk("t2_br",       64'(stat_branches),    64'd1);
        chk("t2_mis",      64'(stat_mispredicts), 64'd0);
        idle();
        chk("t2_fb_pulse", 64'(fb_valid), 64'd0);
        chk("t2_fb_hold",  fb_pc,         64'h200);

        // 3: wrong target; a same-cycle alloc is discarded by the flush
        do_reset();
        step(1, 64'h300, 1, 64'h400, 0, 0, 0);
        step(1, 64'h304, 0, 0, 0, 0, 0);
        step(1, 64'h308, 0, 0, 0, 0, 0);
        step(1, 64'h30C, 0, 0, 1, 1, 64'h480);
        chk("t3_redirect", 64'(redirect_valid),   64'd1);
        chk("t3_rpc",      redirect_pc,           64'h480);
        chk("t3_count",    64'(count),            64'd0);
        chk("t3_mis",      64'(stat_mispredicts), 64'd1);
        idle();
        chk("t3_rpulse", 64'(redirect_valid), 64'd0);

        // 4: fall-through PC wraps modulo 2^64
        do_reset();
        step(1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h1000, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("t4_redirect", 64'(redirect_valid), 64'd1);
        chk("t4_rpc",      redirect_pc,         64'h0);

        // 5: full + resolve refuses alloc; steady push/pop exercises pointer wrap
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 64'h500 + 4*i, 0, 0, 0, 0, 0);
        step(1, 64'h5F0, 0, 0, 1, 0, 0);
        chk("t5_count7", 64'(count), 64'd7);
        chk("t5_fb_pc",  fb_pc,      64'h500);
        for (int k = 0; k < 20; k++) step(1, 64'h600 + 4*k, 0, 0, 1, 0, 0);
        chk("t5_count_steady", 64'(count),         64'd7);
        chk("t5_fb_last",      fb_pc,              64'h630);
        chk("t5_br",           64'(stat_branches), 64'd21);

        // 6: resolve on empty, then reset wins over a pending resolve
        do_reset();
        step(0, 0, 0, 0, 1, 1, 64'h77);
        chk("t6_err",     64'(res_err),  64'd1);
        chk("t6_no_fb",   64'(fb_valid), 64'd0);
        idle();
        chk("t6_err_end", 64'(res_err),  64'd0);
        for (int i = 0; i < 5; i++) step(1, 64'h700 + 4*i, 1, 64'h900, 0, 0, 0);
        chk("t6_count5", 64'(count), 64'd5);
        rst = 1;
        step(1, 64'h800, 0, 0, 1, 0, 0);
        rst = 0;
        chk("t6_rst_count", 64'(count),          64'd0);
        chk("t6_rst_fb",    64'(fb_valid),       64'd0);
        chk("t6_rst_rv",    64'(redirect_valid), 64'd0);
        chk("t6_rst_br",    64'(stat_branches),  64'd0);
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
